step_pulse_gen: RTL and testbench

//  - Per-axis step/dir output stage, instantiated once per axis directly downstream of the DDA interpolator.
//  - Consumes 1-cycle step strobes plus direction and queues them in a small FIFO.
//  - Emits active-low step pulses with guaranteed low/high widths and a direction setup time before the first pulse after a reversal.
//  - Tracks absolute signed position in steps.

---
 rtl/step_gen_pkg.sv | 18 +
 rtl/step_dir_fifo.sv | 40 ++++
 rtl/step_pulse_gen.sv | 113 +++++++++++
 tb/tb_step_pulse_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
// step_gen_pkg: FSM state encoding and default timing for the step/dir output stage
package step_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_PULSE_LOW  = 5000;
    localparam int DEF_PULSE_HIGH = 5000;
    localparam int DEF_DIR_SETUP  = 250;
    localparam int DEF_PEND_W     = 4;
    localparam int DEF_POS_W      = 24;

endpackage

// File: rtl/step_dir_fifo.sv
// step_dir_fifo: 1-bit wide direction FIFO of depth 2**PEND_W with occupancy count
module step_dir_fifo #(
    parameter int PEND_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            din,
    output logic            dout,
    output logic            full,
    output logic            empty,
    output logic [PEND_W:0] count
);

    logic [2**PEND_W-1:0] mem;
    logic [PEND_W-1:0]    wp;
    logic [PEND_W-1:0]    rp;

    assign dout  = mem[rp];
    assign full  = count == (PEND_W+1)'(2**PEND_W);
    assign empty = count == '0;

    // storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

    // pointers and occupancy; callers never push when full without popping, nor pop when empty
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + 1'b1 : wp;
            rp    <= pop ? rp + 1'b1 : rp;
            count <= count + (PEND_W+1)'(push) - (PEND_W+1)'(pop);
        end

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: queued step/dir pulse generator with position tracking; optional SOFT_LIMIT_EN adds soft limits
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PULSE_LOW  = DEF_PULSE_LOW,
    parameter int PULSE_HIGH = DEF_PULSE_HIGH,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int PEND_W     = DEF_PEND_W,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_req,
    input  logic             step_dir,
    input  logic             clr_pos,
    output logic             step_n,
    output logic             dir,
    output logic             busy,
    output logic [PEND_W:0]  pending,
    output logic [POS_W-1:0] position,
    output logic             overrun
`ifdef SOFT_LIMIT_EN
    ,
    input  logic [POS_W-1:0] pos_min,
    input  logic [POS_W-1:0] pos_max,
    output logic             limit_hit
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dir_int;
    logic             head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             discard;
    logic             enter_low;
    logic [POS_W-1:0] step_inc;

    assign pop       = state == IDLE && !empty;
    assign push      = step_req && (!full || pop);
    assign busy      = state != IDLE || !empty;
    assign enter_low = state_nxt == LOW && state != LOW;
    assign step_inc  = {{(POS_W-1){dir_int}}, 1'b1};

`ifdef SOFT_LIMIT_EN
    assign discard = pop && (head ? $signed(position) <= $signed(pos_min)
                                  : $signed(position) >= $signed(pos_max));
`else
    assign discard = 1'b0;
`endif

    step_dir_fifo #(.PEND_W(PEND_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (step_dir),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    // next state: a reversal detours through SETUP so dir settles before the falling edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && !discard) state_nxt = (head != dir_int) ? SETUP : LOW;
            SETUP:   if (cnt == CNT_W'(DIR_SETUP - 1)) state_nxt = LOW;
            LOW:     if (cnt == CNT_W'(PULSE_LOW - 1)) state_nxt = HIGH;
            default: if (cnt == CNT_W'(PULSE_HIGH - 1)) state_nxt = IDLE;
        endcase
    end

    // FSM, timing counter and registered step/dir outputs; async reset drops step_n high at once
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dir_int <= 1'b0;
            step_n  <= 1'b1;
            dir     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
            dir_int <= (state == IDLE && state_nxt == SETUP) ? head : dir_int;
            step_n  <= state != LOW;
            dir     <= dir_int;
        end

    // position moves on LOW entry; clr_pos wins over a coincident step and clears overrun
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            position <= '0;
            overrun  <= 1'b0;
        end else begin
            position <= clr_pos ? '0 : enter_low ? position + step_inc : position;
            overrun  <= clr_pos ? 1'b0 : overrun | (step_req && !push);
        end

`ifdef SOFT_LIMIT_EN
    // one-cycle flag for a step swallowed by the soft limits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) limit_hit <= 1'b0;
        else        limit_hit <= discard;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: randomized check of step_pulse_gen against a schedule-level model; honours SOFT_LIMIT_EN
module tb_step_pulse_gen;

    localparam int PL    = 4;
    localparam int PH    = 3;
    localparam int DS    = 2;
    localparam int PW    = 2;
    localparam int POSW  = 8;
    localparam int DEPTH = 2**PW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            step_req;
    logic            step_dir;
    logic            clr_pos;
    logic            step_n;
    logic            dir;
    logic            busy;
    logic [PW:0]     pending;
    logic [POSW-1:0] position;
    logic            overrun;
`ifdef SOFT_LIMIT_EN
    logic [POSW-1:0] pos_min = -8'sd3;
    logic [POSW-1:0] pos_max = 8'sd2;
    logic            limit_hit;
`endif

    step_pulse_gen #(
        .CNT_W(16), .PULSE_LOW(PL), .PULSE_HIGH(PH), .DIR_SETUP(DS), .PEND_W(PW), .POS_W(POSW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_req (step_req),
        .step_dir (step_dir),
        .clr_pos  (clr_pos),
        .step_n   (step_n),
        .dir      (dir),
        .busy     (busy),
        .pending  (pending),
        .position (position),
        .overrun  (overrun)
`ifdef SOFT_LIMIT_EN
        ,
        .pos_min  (pos_min),
        .pos_max  (pos_max),
        .limit_hit(limit_hit)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // schedule model: each popped step books a low window and the earliest next pop edge
    int              n = 0;
    bit              q[$];
    int              next_pop;
    int              lw_s;
    int              lw_e;
    int              pos_edge;
    bit              pos_neg;
    bit              m_dir;
    bit              m_dir_out;
    bit              m_ovr;
    bit              m_lh;
    logic [POSW-1:0] m_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_pop  = 0;
        lw_s      = -1;
        lw_e      = -2;
        pos_edge  = -1;
        pos_neg   = 0;
        m_dir     = 0;
        m_dir_out = 0;
        m_ovr     = 0;
        m_lh      = 0;
        m_pos     = '0;
    endtask

    task automatic model_edge(input bit req, input bit rd, input bit clr);
        bit pop, acc, h, disc;
        int s;
        n++;
        m_dir_out = m_dir;
        m_lh = 0;
        pop = q.size() != 0 && n >= next_pop;
        acc = req && (q.size() < DEPTH || pop);
        if (pop) begin
            h = q.pop_front();
            disc = 0;
`ifdef SOFT_LIMIT_EN
            disc = h ? $signed(m_pos) <= $signed(pos_min) : $signed(m_pos) >= $signed(pos_max);
`endif
            if (disc) begin
                m_lh = 1;
                next_pop = n + 1;
            end else begin
                s = (h != m_dir) ? DS : 0;
                lw_s = n + 1 + s;
                lw_e = n + s + PL;
                pos_edge = n + s;
                pos_neg = h;
                next_pop = n + s + PL + PH + 1;
                m_dir = h;
            end
        end
        if (acc) q.push_back(rd);
        if (clr) m_pos = '0;
        else if (n == pos_edge) m_pos = pos_neg ? m_pos - 1'b1 : m_pos + 1'b1;
        if (clr) m_ovr = 0;
        else if (req && !acc) m_ovr = 1;
    endtask

    function automatic bit exp_step_n();
        return !(n >= lw_s && n <= lw_e);
    endfunction

    task automatic check_all();
        check("step_n", 32'(step_n), 32'(exp_step_n()));
        check("dir", 32'(dir), 32'(m_dir_out));
        check("busy", 32'(busy), 32'(q.size() != 0 || n < next_pop - 1));
        check("pending", 32'(pending), 32'(q.size()));
        check("position", 32'(position), 32'(m_pos));
        check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SOFT_LIMIT_EN
        check("limit_hit", 32'(limit_hit), 32'(m_lh));
`endif
    endtask

    initial begin
        bit rst_done = 0;
        bit sdir = 0;
        int rate;
        rst_n = 1'b0;
        step_req = 1'b0;
        step_dir = 1'b0;
        clr_pos = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            case (c / 1000)
                0:       rate = 4;
                1:       rate = 70;
                2:       rate = 15;
                3:       rate = 90;
                default: rate = 30;
            endcase
            if (c % 2000 < 1000) sdir = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 15) == 0) sdir = ~sdir;
            step_req = $urandom_range(0, 99) < rate;
            step_dir = sdir;
            clr_pos  = $urandom_range(0, 299) == 0;
            model_edge(step_req, step_dir, clr_pos);
            @(negedge clk);
            check_all();
            if (!rst_done && c > 2500 && !exp_step_n()) begin
                rst_done = 1;
                step_req = 1'b0;
                clr_pos = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_step_n", 32'(step_n), 32'd1);
                check("rst_pending", 32'(pending), 32'd0);
                check("rst_position", 32'(position), 32'd0);
                model_reset();
                @(negedge clk);
                n++;
                check_all();
                rst_n = 1'b1;
            end
        end
        check("reset_in_low_seen", 32'(rst_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
